alu_dec_pipe: RTL

//  Registered, handshaked ALU decoder for the execute stage. Maps ALUOp/funct3/funct7
//  to a 4-bit ALU control for the full RV32I ALU set plus the optional M extension.
//  M ops hold the output for a parametrised multi-cycle latency.

---
 rtl/alu_dec_pipe_pkg.sv | 47 ++++
 rtl/alu_dec_pipe_if.sv | 29 ++
 rtl/alu_dec_pipe_comb.sv | 63 ++++++
 rtl/alu_dec_pipe.sv | 124 ++++++++++++
 4 files changed

// File: rtl/alu_dec_pipe_pkg.sv
// Shared types and constants for the execute-stage ALU decoder:
// ALU control codes, ALUOp encodings, funct7 classes, FSM states.
package alu_dec_pipe_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_SUB   = 4'b0001,
    ALU_AND   = 4'b0010,
    ALU_OR    = 4'b0011,
    ALU_XOR   = 4'b0100,
    ALU_SLT   = 4'b0101,
    ALU_SLTU  = 4'b0110,
    ALU_SLL   = 4'b0111,
    ALU_SRL   = 4'b1000,
    ALU_SRA   = 4'b1001,
    ALU_PASSB = 4'b1010
  } alu_ctrl_e;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_PASSB = 2'b11;

  localparam logic [6:0] FUNCT7_BASE   = 7'h00;
  localparam logic [6:0] FUNCT7_ALT    = 7'h20;
  localparam logic [6:0] FUNCT7_MULDIV = 7'h01;

  localparam logic [2:0] F3_ADDSUB = 3'b000;
  localparam logic [2:0] F3_SLL    = 3'b001;
  localparam logic [2:0] F3_SLT    = 3'b010;
  localparam logic [2:0] F3_SLTU   = 3'b011;
  localparam logic [2:0] F3_XOR    = 3'b100;
  localparam logic [2:0] F3_SR     = 3'b101;
  localparam logic [2:0] F3_OR     = 3'b110;
  localparam logic [2:0] F3_AND    = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_COUNT = 2'b01,
    ST_HOLD  = 2'b10
  } dec_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/alu_dec_pipe_if.sv
// Decode-field / result handshake bundle between the main decoder,
// the ALU decoder and the ALU/multiplier consumer.
interface alu_dec_pipe_if;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] ALUOp;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       op_5;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] alu_ctrl;
  logic       m_op;
  logic       illegal;
  logic       busy;

  // Upstream/consumer side: supplies fields, flush and output back-pressure.
  modport master (
    output flush, in_valid, ALUOp, funct3, funct7, op_5, out_ready,
    input  in_ready, out_valid, alu_ctrl, m_op, illegal, busy
  );

  // Decoder side.
  modport slave (
    input  flush, in_valid, ALUOp, funct3, funct7, op_5, out_ready,
    output in_ready, out_valid, alu_ctrl, m_op, illegal, busy
  );
endinterface

// File: rtl/alu_dec_pipe_comb.sv
// Pure combinational decode of ALUOp/funct3/funct7/op_5 into the
// 4-bit ALU control, the M-extension flag and the illegal flag.
module alu_dec_pipe_comb
  import alu_dec_pipe_pkg::*;
#(
  parameter bit EN_M = 1'b1
) (
  input  logic [1:0] i_aluop,
  input  logic [2:0] i_funct3,
  input  logic [6:0] i_funct7,
  input  logic       i_op_5,
  output alu_ctrl_e  o_alu_ctrl,
  output logic       o_m_op,
  output logic       o_illegal
);

  logic w_f7_std;
  logic w_is_m;
  logic w_is_shift;
  logic w_bad;

  // funct7 of 0x00/0x20 are the only encodings the base ISA defines.
  assign w_f7_std   = (i_funct7 == FUNCT7_BASE) || (i_funct7 == FUNCT7_ALT);
  assign w_is_m     = EN_M && i_op_5 && (i_funct7 == FUNCT7_MULDIV);
  assign w_is_shift = (i_funct3 == F3_SLL) || (i_funct3 == F3_SR);
  // M ops are tested first, so any remaining R-type funct7 outside the base
  // set (including 0x01 when M is disabled) is illegal; shifts carry funct7
  // in the immediate too, so they are checked for both R and I forms.
  assign w_bad      = !w_f7_std && (i_op_5 || w_is_shift);

  // Field decode; illegal combinations fall back to ADD with m_op low.
  always_comb begin
    o_alu_ctrl = ALU_ADD;
    o_m_op     = 1'b0;
    o_illegal  = 1'b0;
    case (i_aluop)
      ALUOP_ADD:   o_alu_ctrl = ALU_ADD;
      ALUOP_SUB:   o_alu_ctrl = ALU_SUB;
      ALUOP_PASSB: o_alu_ctrl = ALU_PASSB;
      default: begin
        if (w_is_m) begin
          o_m_op     = 1'b1;
          o_alu_ctrl = alu_ctrl_e'({1'b0, i_funct3});
        end else if (w_bad) begin
          o_illegal  = 1'b1;
        end else begin
          case (i_funct3)
            F3_ADDSUB: o_alu_ctrl = (i_op_5 && i_funct7[5]) ? ALU_SUB : ALU_ADD;
            F3_SLL:    o_alu_ctrl = ALU_SLL;
            F3_SLT:    o_alu_ctrl = ALU_SLT;
            F3_SLTU:   o_alu_ctrl = ALU_SLTU;
            F3_XOR:    o_alu_ctrl = ALU_XOR;
            F3_SR:     o_alu_ctrl = i_funct7[5] ? ALU_SRA : ALU_SRL;
            F3_OR:     o_alu_ctrl = ALU_OR;
            F3_AND:    o_alu_ctrl = ALU_AND;
            default:   o_alu_ctrl = ALU_ADD;
          endcase
        end
      end
    endcase
  end

endmodule

// File: rtl/alu_dec_pipe.sv
// Registered, handshaked ALU decoder. Single-cycle ops appear one cycle
// after accept; M ops are held back for MUL_CYCLES / DIV_CYCLES so the
// multiplier/divider result and the control arrive together.
module alu_dec_pipe
  import alu_dec_pipe_pkg::*;
#(
  parameter bit EN_M       = 1'b1,
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 32
) (
  input  logic          clk,
  input  logic          rst,
  alu_dec_pipe_if.slave bus
);

  localparam int CNT_MAX = max_int(MUL_CYCLES, DIV_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  dec_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_out_valid;
  logic             r_busy;
  alu_ctrl_e        r_alu_ctrl;
  logic             r_m_op;
  logic             r_illegal;

  alu_ctrl_e        w_dec_ctrl;
  logic             w_dec_m;
  logic             w_dec_ill;
  logic             w_in_ready;
  logic             w_accept;
  logic [CNT_W-1:0] w_load;

  alu_dec_pipe_comb #(
    .EN_M (EN_M)
  ) u_comb (
    .i_aluop    (bus.ALUOp),
    .i_funct3   (bus.funct3),
    .i_funct7   (bus.funct7),
    .i_op_5     (bus.op_5),
    .o_alu_ctrl (w_dec_ctrl),
    .o_m_op     (w_dec_m),
    .o_illegal  (w_dec_ill)
  );

  // A held result can be replaced in the same cycle it is consumed, which
  // is what gives 1/cycle throughput for single-cycle ops.
  assign w_in_ready = (r_state == ST_IDLE) ||
                      ((r_state == ST_HOLD) && bus.out_ready);
  // Inputs presented alongside a flush belong to the redirected path.
  assign w_accept   = bus.in_valid && w_in_ready && !bus.flush;
  // Remaining COUNT cycles after accept; zero means straight to HOLD.
  assign w_load     = !w_dec_m      ? '0       :
                      bus.funct3[2] ? DIV_LOAD : MUL_LOAD;

  // Control FSM, countdown and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_alu_ctrl  <= ALU_ADD;
      r_m_op      <= 1'b0;
      r_illegal   <= 1'b0;
    end else if (bus.flush) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else if (w_accept) begin
      r_alu_ctrl <= w_dec_ctrl;
      r_m_op     <= w_dec_m;
      r_illegal  <= w_dec_ill;
      r_cnt      <= w_load;
      if (w_load != '0) begin
        r_state     <= ST_COUNT;
        r_out_valid <= 1'b0;
        r_busy      <= 1'b1;
      end else begin
        r_state     <= ST_HOLD;
        r_out_valid <= 1'b1;
        r_busy      <= 1'b0;
      end
    end else begin
      case (r_state)
        ST_COUNT: begin
          r_cnt <= r_cnt - CNT_ONE;
          if ((r_cnt == CNT_ONE) || (r_cnt == '0)) begin
            r_cnt       <= '0;
            r_state     <= ST_HOLD;
            r_out_valid <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (bus.out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
          end
        end
        ST_IDLE: begin
        end
        default: begin
          r_state     <= ST_IDLE;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_cnt       <= '0;
        end
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.busy      = r_busy;
  assign bus.alu_ctrl  = r_alu_ctrl;
  assign bus.m_op      = r_m_op;
  assign bus.illegal   = r_illegal;

endmodule
